// File: rtl/census_pkg.sv
// Shared definitions for the census window controller: FSM state encoding,
// default coordinate widths and the windows-per-frame formula.
package census_pkg;

  // Controller state: waiting for a start-of-frame, or inside a frame.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Default image geometry and the coordinate widths derived from it.
  localparam int unsigned IMG_WIDTH_DEF  = 320;
  localparam int unsigned IMG_HEIGHT_DEF = 240;
  localparam int unsigned COL_W          = $clog2(IMG_WIDTH_DEF);
  localparam int unsigned ROW_W          = $clog2(IMG_HEIGHT_DEF);

  // Number of fully populated windows produced by one frame.
  function automatic int unsigned window_count(input int unsigned img_w,
                                               input int unsigned img_h,
                                               input int unsigned win_w,
                                               input int unsigned win_h);
    return (img_w - win_w + 1) * (img_h - win_h + 1);
  endfunction

endpackage : census_pkg

// File: rtl/census_pos_counter.sv
// Raster position counter: column/row of the pixel being presented, with
// increment-on-enable, line/frame wrap, synchronous clear to (0,0) and a
// flag for the last pixel of the frame.
module census_pos_counter #(
  parameter int unsigned IMG_WIDTH  = 320,
  parameter int unsigned IMG_HEIGHT = 240,
  localparam int unsigned CW = $clog2(IMG_WIDTH),
  localparam int unsigned RW = $clog2(IMG_HEIGHT)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,       // a pixel is consumed at the current position
  input  logic          clr,      // current pixel is a frame start: treat it as (0,0)
  output logic [CW-1:0] col,      // column of the current pixel
  output logic [RW-1:0] row,      // row of the current pixel
  output logic          last      // current pixel is the last one of the frame
);

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;

  // Current position: a clear overrides the stored position in the same cycle.
  always_comb begin
    col  = clr ? '0 : col_q;
    row  = clr ? '0 : row_q;
    last = (col == COL_LAST) && (row == ROW_LAST);
  end

  // Next position: step past the current pixel, wrapping at line and frame end.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    col_d = col_q;
    row_d = row_q;
    if (en) begin
      if (col == COL_LAST) begin
        col_d = '0;
        row_d = (row == ROW_LAST) ? '0 : row + 1'b1;
      end else begin
        col_d = col + 1'b1;
        row_d = row;
      end
    end else if (clr) begin
      col_d = '0;
      row_d = '0;
    end
  end

  // Position register with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

endmodule : census_pos_counter

// File: rtl/census_window_ctrl.sv
// Census window controller: accepts a raster pixel stream, tracks position,
// strobes the line-buffer shift and census register enable, and emits a
// valid/ready stream of window-centre coordinates for fully populated windows.
// Optional statistics ports (frame_cnt, drop_cnt) exist only when the macro
// CENSUS_CTRL_STATS_EN is defined.
module census_window_ctrl
  import census_pkg::*;
#(
  parameter int unsigned IMG_WIDTH     = 320,
  parameter int unsigned IMG_HEIGHT    = 240,
  parameter int unsigned WINDOW_WIDTH  = 3,
  parameter int unsigned WINDOW_HEIGHT = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  input  logic                          in_sof,
  output logic                          in_ready,
  output logic                          shift_en,
  output logic                          census_en,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(IMG_WIDTH)-1:0]  out_col,
  output logic [$clog2(IMG_HEIGHT)-1:0] out_row,
  output logic                          out_eof,
  output logic                          sof_err
`ifdef CENSUS_CTRL_STATS_EN
  ,
  output logic [15:0]                   frame_cnt,
  output logic [15:0]                   drop_cnt
`endif
);

  localparam int unsigned CW     = $clog2(IMG_WIDTH);
  localparam int unsigned RW     = $clog2(IMG_HEIGHT);
  localparam int unsigned HALF_W = (WINDOW_WIDTH - 1) / 2;
  localparam int unsigned HALF_H = (WINDOW_HEIGHT - 1) / 2;

  localparam logic [CW-1:0] WIN_COL_MIN = CW'(WINDOW_WIDTH - 1);
  localparam logic [RW-1:0] WIN_ROW_MIN = RW'(WINDOW_HEIGHT - 1);
  localparam logic [CW-1:0] COL_OFS     = CW'(HALF_W);
  localparam logic [RW-1:0] ROW_OFS     = RW'(HALF_H);

  state_e        state_q, state_d;

  logic          out_valid_q, out_valid_d;
  logic [CW-1:0] out_col_q,   out_col_d;
  logic [RW-1:0] out_row_q,   out_row_d;
  logic          out_eof_q,   out_eof_d;
  logic          sof_err_q,   sof_err_d;

  logic          adv;
  logic          resync;
  logic          pix_clr;
  logic          win_done;
  logic [CW-1:0] pix_col;
  logic [RW-1:0] pix_row;
  logic          pix_last;

  // The output stage may take a new result when it is empty or being drained.
  assign adv       = ~out_valid_q | out_ready;
  assign census_en = adv;

  // Any accepted SOF pixel, from IDLE or as a resync, is placed at (0,0).
  assign pix_clr = shift_en & in_sof;

  census_pos_counter #(
    .IMG_WIDTH  (IMG_WIDTH),
    .IMG_HEIGHT (IMG_HEIGHT)
  ) u_pos (
    .clk  (clk),
    .rst  (rst),
    .en   (shift_en),
    .clr  (pix_clr),
    .col  (pix_col),
    .row  (pix_row),
    .last (pix_last)
  );

  // The current pixel completes a window once enough columns and rows are buffered.
  assign win_done = (pix_col >= WIN_COL_MIN) && (pix_row >= WIN_ROW_MIN);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // FSM next state: SOF starts a frame, acceptance of the last pixel ends it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (shift_en)             state_d = ST_RUN;
      ST_RUN:  if (shift_en && pix_last) state_d = ST_IDLE;
      default:                           state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: IDLE swallows non-SOF pixels, RUN follows output back-pressure.
  always_comb begin
    in_ready = 1'b1;
    shift_en = 1'b0;
    resync   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        shift_en = in_valid & in_sof;
      end
      ST_RUN: begin
        in_ready = adv;
        shift_en = in_valid & adv;
        resync   = in_valid & adv & in_sof;
      end
      default: begin
        in_ready = 1'b1;
        shift_en = 1'b0;
      end
    endcase
  end

  // Result stage: load on advance, otherwise hold until the handshake completes.
  always_comb begin
    out_valid_d = out_valid_q;
    out_col_d   = out_col_q;
    out_row_d   = out_row_q;
    out_eof_d   = out_eof_q;
    if (adv) begin
      out_valid_d = shift_en & win_done;
      out_col_d   = pix_col - COL_OFS;
      out_row_d   = pix_row - ROW_OFS;
      out_eof_d   = shift_en & win_done & pix_last;
    end
    sof_err_d = sof_err_q | resync;
  end

  // Result and error registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_col_q   <= '0;
      out_row_q   <= '0;
      out_eof_q   <= 1'b0;
      sof_err_q   <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_col_q   <= out_col_d;
      out_row_q   <= out_row_d;
      out_eof_q   <= out_eof_d;
      sof_err_q   <= sof_err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_col   = out_col_q;
  assign out_row   = out_row_q;
  assign out_eof   = out_eof_q;
  assign sof_err   = sof_err_q;

`ifdef CENSUS_CTRL_STATS_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic [15:0] drop_cnt_q,  drop_cnt_d;

  // Saturating counters of completed frames and pixels discarded while idle.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    if (out_valid_q && out_ready && out_eof_q && !(&frame_cnt_q))
      frame_cnt_d = frame_cnt_q + 16'd1;
    if ((state_q == ST_IDLE) && in_valid && !in_sof && !(&drop_cnt_q))
      drop_cnt_d = drop_cnt_q + 16'd1;
  end

  // Statistics registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign frame_cnt = frame_cnt_q;
  assign drop_cnt  = drop_cnt_q;
`endif

endmodule : census_window_ctrl

// File: tb/tb_census_window_ctrl.sv
// Self-checking bench for census_window_ctrl on an 8x6 image with a 3x3 window.
module tb_census_window_ctrl;

  localparam int IW   = 8;
  localparam int IH   = 6;
  localparam int WW   = 3;
  localparam int WH   = 3;
  localparam int NPIX = IW * IH;
  localparam int NWIN = 24;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_sof, in_ready;
  logic       shift_en, census_en;
  logic       out_valid, out_ready;
  logic [2:0] out_col, out_row;
  logic       out_eof, sof_err;
`ifdef CENSUS_CTRL_STATS_EN
  logic [15:0] frame_cnt, drop_cnt;
`endif

  always #5 clk = ~clk;

  census_window_ctrl #(
    .IMG_WIDTH     (IW),
    .IMG_HEIGHT    (IH),
    .WINDOW_WIDTH  (WW),
    .WINDOW_HEIGHT (WH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_sof    (in_sof),
    .in_ready  (in_ready),
    .shift_en  (shift_en),
    .census_en (census_en),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_col   (out_col),
    .out_row   (out_row),
    .out_eof   (out_eof),
    .sof_err   (sof_err)
`ifdef CENSUS_CTRL_STATS_EN
    ,
    .frame_cnt (frame_cnt),
    .drop_cnt  (drop_cnt)
`endif
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model: pixel index -> expected windows ----------------
  typedef struct {
    int col;
    int row;
    bit eof;
    int acc_cyc;
  } exp_t;

  typedef struct {
    int col;
    int row;
    bit eof;
  } res_t;

  exp_t exp_q[$];
  res_t res_log[$];

  bit   mon_en    = 1'b0;
  bit   strict    = 1'b0;
  int   ord_mode  = 0;
  int   cyc       = 0;
  bit   m_active  = 1'b0;
  bit   m_sof_err = 1'b0;
  int   m_k       = 0;
  int   m_frames  = 0;
  int   m_drops   = 0;
  bit   m_exp_rdy, m_acc, m_exp_shift;
  int   m_c, m_r;
  exp_t m_e;
  res_t m_res;
  bit   hold_pend = 1'b0;
  res_t hold_v;

  // Monitor: sample at the falling edge the handshakes the next rising edge will perform.
  always @(negedge clk) begin
    cyc++;
    if (mon_en) begin
      if (rst) begin
        exp_q.delete();
        m_active  = 1'b0;
        m_sof_err = 1'b0;
        m_frames  = 0;
        m_drops   = 0;
        hold_pend = 1'b0;
      end else begin
        check("sof_err", sof_err, m_sof_err);
        m_exp_rdy = m_active ? (!out_valid || out_ready) : 1'b1;
        check("in_ready", in_ready, m_exp_rdy);
        check("census_en", census_en, !out_valid || out_ready);
        m_acc       = in_valid && m_exp_rdy;
        m_exp_shift = m_acc && (m_active || in_sof);
        check("shift_en", shift_en, m_exp_shift);

        if (hold_pend) begin
          check("hold_valid", out_valid, 1);
          check("hold_col", out_col, hold_v.col);
          check("hold_row", out_row, hold_v.row);
          check("hold_eof", out_eof, hold_v.eof);
        end
        hold_pend  = out_valid && !out_ready;
        hold_v.col = out_col;
        hold_v.row = out_row;
        hold_v.eof = out_eof;

        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_out_valid", out_valid, 0);
          end else begin
            m_e = exp_q.pop_front();
            check("out_col", out_col, m_e.col);
            check("out_row", out_row, m_e.row);
            check("out_eof", out_eof, m_e.eof);
            if (strict) check("latency_cycle", cyc, m_e.acc_cyc + 1);
            if (m_e.eof) m_frames++;
          end
          m_res.col = out_col;
          m_res.row = out_row;
          m_res.eof = out_eof;
          res_log.push_back(m_res);
        end

        if (m_acc) begin
          if (in_sof || m_active) begin
            if (in_sof) begin
              if (m_active) m_sof_err = 1'b1;
              m_k = 0;
            end else begin
              m_k++;
            end
            m_active = 1'b1;
            m_c = m_k % IW;
            m_r = m_k / IW;
            if (m_c >= WW - 1 && m_r >= WH - 1) begin
              m_e.col     = m_c - (WW - 1) / 2;
              m_e.row     = m_r - (WH - 1) / 2;
              m_e.eof     = (m_k == NPIX - 1);
              m_e.acc_cyc = cyc;
              exp_q.push_back(m_e);
            end
            if (m_k == NPIX - 1) m_active = 1'b0;
          end else begin
            m_drops++;
          end
        end
      end
    end
  end

  // Downstream ready: constant, alternating, or random.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ord_mode)
        1:       out_ready = ~out_ready;
        2:       out_ready = ($urandom_range(0, 3) != 0);
        default: out_ready = 1'b1;
      endcase
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_px(input bit sof);
    bit acc;
    bit done;
    done     = 1'b0;
    in_valid = 1'b1;
    in_sof   = sof;
    for (int t = 0; t < 200 && !done; t++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) done = 1'b1;
    end
    in_valid = 1'b0;
    in_sof   = 1'b0;
    check("send_timeout", done, 1);
  endtask

  task automatic send_frame(input int gap_max);
    send_px(1'b1);
    for (int k = 1; k < NPIX; k++) begin
      if (gap_max > 0) idle($urandom_range(0, gap_max));
      send_px(1'b0);
    end
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 500 && !ok; t++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !out_valid) ok = 1'b1;
    end
    check("drain_timeout", ok, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // ---------------- vector table for the idle phase ----------------
  typedef struct {
    bit v;
    bit sof;
    bit exp_rdy;
    bit exp_shift;
  } vec_t;

  vec_t tbl[12];
  int   base;

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_sof   = 1'b0;

    for (int i = 0; i < 10; i++) tbl[i] = '{v: 1'b1, sof: 1'b0, exp_rdy: 1'b1, exp_shift: 1'b0};
    tbl[10] = '{v: 1'b0, sof: 1'b0, exp_rdy: 1'b1, exp_shift: 1'b0};
    tbl[11] = '{v: 1'b0, sof: 1'b1, exp_rdy: 1'b1, exp_shift: 1'b0};

    // Reset state.
    idle(3);
    rst    = 1'b0;
    mon_en = 1'b1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_sof_err", sof_err, 0);
    check("rst_out_col", out_col, 0);
    check("rst_out_row", out_row, 0);
    check("rst_out_eof", out_eof, 0);

    // Stray pixels in IDLE are swallowed without shifting.
    for (int i = 0; i < 12; i++) begin
      in_valid = tbl[i].v;
      in_sof   = tbl[i].sof;
      @(negedge clk);
      check($sformatf("tbl%0d_in_ready", i), in_ready, tbl[i].exp_rdy);
      check($sformatf("tbl%0d_shift_en", i), shift_en, tbl[i].exp_shift);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_sof   = 1'b0;
    check("idle_out_valid", out_valid, 0);

    // Full-rate frame: one result per cycle, exact latency.
    strict = 1'b1;
    base   = res_log.size();
    send_frame(0);
    drain();
    strict = 1'b0;
    check("p1_count", res_log.size() - base, NWIN);
    if (res_log.size() - base == NWIN) begin
      check("p1_first_col", res_log[base].col, 1);
      check("p1_first_row", res_log[base].row, 1);
      check("p1_first_eof", res_log[base].eof, 0);
      check("p1_last_col", res_log[base + NWIN - 1].col, 6);
      check("p1_last_row", res_log[base + NWIN - 1].row, 4);
      check("p1_last_eof", res_log[base + NWIN - 1].eof, 1);
    end
    in_valid = 1'b1;
    @(negedge clk);
    check("post_frame_shift_en", shift_en, 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;

    // Same frame with alternating downstream ready.
    ord_mode = 1;
    base     = res_log.size();
    send_frame(0);
    drain();
    ord_mode = 0;
    idle(2);
    check("p2_count", res_log.size() - base, NWIN);

    // Resync: SOF again at pixel 30.
    strict = 1'b1;
    base   = res_log.size();
    send_px(1'b1);
    for (int k = 1; k < 30; k++) send_px(1'b0);
    send_px(1'b1);
    for (int k = 1; k < NPIX; k++) send_px(1'b0);
    drain();
    strict = 1'b0;
    check("p3_count", res_log.size() - base, 10 + NWIN);
    check("p3_sof_err", sof_err, 1);
    if (res_log.size() - base == 10 + NWIN)
      check("p3_last_eof", res_log[base + 10 + NWIN - 1].eof, 1);
    idle(3);
    check("p3_sof_err_sticky", sof_err, 1);

    // Reset mid-frame after pixel 24, then a clean frame.
    send_px(1'b1);
    for (int k = 1; k < 25; k++) send_px(1'b0);
    pulse_reset();
    check("p4_out_valid", out_valid, 0);
    check("p4_in_ready", in_ready, 1);
    check("p4_sof_err", sof_err, 0);
    base = res_log.size();
    send_frame(0);
    drain();
    check("p4_count", res_log.size() - base, NWIN);

    // Random input gaps, random downstream ready, stray pixels between frames.
    ord_mode = 2;
    base     = res_log.size();
    for (int f = 0; f < 2; f++) begin
      repeat ($urandom_range(0, 3)) send_px(1'b0);
      send_frame(3);
    end
    drain();
    ord_mode = 0;
    idle(2);
    check("p5_count", res_log.size() - base, 2 * NWIN);

    // Three frames plus five stray pixels after a reset.
    pulse_reset();
    base = res_log.size();
    send_px(1'b0);
    send_px(1'b0);
    send_frame(0);
    send_px(1'b0);
    send_px(1'b0);
    send_px(1'b0);
    send_frame(0);
    send_frame(0);
    drain();
    check("p6_count", res_log.size() - base, 3 * NWIN);
`ifdef CENSUS_CTRL_STATS_EN
    check("frame_cnt", frame_cnt, 3);
    check("drop_cnt", drop_cnt, 5);
    check("frame_cnt_model", frame_cnt, m_frames);
    check("drop_cnt_model", drop_cnt, m_drops);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_census_window_ctrl
